// File: rtl/conv3x3_mac_sequencer.sv
// Feeds one 3x3 window to a shared 3-tap MAC row by row, captures the sum and hands it downstream.
// Define SAT_CLIP_EN to clamp the captured result to 0..255; otherwise the raw signed sum is passed.
module conv3x3_mac_sequencer #(
  parameter int MAC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [71:0] cfg_weight,
  input  logic        win_valid,
  output logic        win_ready,
  input  logic [71:0] win_data,
  output logic        mac_start,
  output logic [23:0] mac_data,
  output logic [23:0] mac_weight,
  input  logic [19:0] mac_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_pix,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW0,
    S_ROW1,
    S_ROW2,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(MAC_LAT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [71:0] r_shadow;
  // Row 0 goes straight to the MAC at acceptance, so only rows 1 and 2 are kept.
  logic [47:0] r_win;
  logic [47:0] r_active;
  logic [23:0] r_mac_data;
  logic [23:0] r_mac_weight;
  logic        r_mac_start;
  logic [1:0]  r_cnt;
  logic [19:0] r_out_pix;
  logic [19:0] w_result;
  logic        w_accept;
  logic        w_capture;

  assign w_accept  = (r_state == S_IDLE) && win_valid;
  assign w_capture = (r_state == S_WAIT) && (r_cnt == 2'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (win_valid) w_state_next = S_ROW0;
      S_ROW0:  w_state_next = S_ROW1;
      S_ROW1:  w_state_next = S_ROW2;
      S_ROW2:  w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == 2'd0) w_state_next = S_OUT;
      S_OUT:   if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef SAT_CLIP_EN
  always_comb begin
    w_result = mac_result;
    if (mac_result[19]) begin
      w_result = 20'd0;
    end else if (mac_result > 20'd255) begin
      w_result = 20'd255;
    end
  end
`else
  assign w_result = mac_result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_win        <= '0;
      r_active     <= '0;
      r_mac_data   <= '0;
      r_mac_weight <= '0;
      r_mac_start  <= 1'b0;
      r_cnt        <= '0;
      r_out_pix    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mac_start <= w_accept;
      // Shadow is read before this write, so a same-cycle load only affects later windows.
      if (cfg_we) begin
        r_shadow <= cfg_weight;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_win        <= win_data[47:0];
            r_active     <= r_shadow[47:0];
            r_mac_data   <= win_data[71:48];
            r_mac_weight <= r_shadow[71:48];
          end
        end
        S_ROW0: begin
          r_mac_data   <= r_win[47:24];
          r_mac_weight <= r_active[47:24];
        end
        S_ROW1: begin
          r_mac_data   <= r_win[23:0];
          r_mac_weight <= r_active[23:0];
        end
        S_ROW2: begin
          r_mac_data   <= '0;
          r_mac_weight <= '0;
          r_cnt        <= CNT_INIT;
        end
        S_WAIT: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
      if (w_capture) begin
        r_out_pix <= w_result;
      end
    end
  end

  assign win_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_OUT);
  assign mac_start  = r_mac_start;
  assign mac_data   = r_mac_data;
  assign mac_weight = r_mac_weight;
  assign out_pix    = r_out_pix;

endmodule

// File: tb/tb_conv3x3_mac_sequencer.sv
// Bench for conv3x3_mac_sequencer: two DUTs (MAC_LAT 1 and 3) each driven by a behavioural MAC,
// checked every cycle against a window-level model plus directed literal expectations.
module tb_conv3x3_mac_sequencer;

  localparam logic [71:0] LAP  = 72'hFFFFFF_FF08FF_FFFFFF;
  localparam logic [71:0] ONES = 72'h010101_010101_010101;
  localparam logic [71:0] W2   = 72'h00FF00_010700_000409;
  localparam logic [71:0] W10  = 72'h0A0A0A_0A0A0A_0A0A0A;
  localparam logic [71:0] WC   = 72'h000000_006400_000000;
`ifdef SAT_CLIP_EN
  localparam logic [19:0] EXP2  = 20'd0;
  localparam logic [19:0] EXP_C = 20'd255;
`else
  localparam logic [19:0] EXP2  = 20'hFFF2B;
  localparam logic [19:0] EXP_C = 20'd800;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]        cfg_we_s = '0;
  logic [1:0][71:0]  cfg_weight_s = '0;
  logic [1:0]        win_valid_s = '0;
  logic [1:0]        win_ready_s;
  logic [1:0][71:0]  win_data_s = '0;
  logic [1:0]        mac_start_s;
  logic [1:0][23:0]  mac_data_s;
  logic [1:0][23:0]  mac_weight_s;
  logic [1:0][19:0]  mac_result_s;
  logic [1:0]        out_valid_s;
  logic [1:0]        out_ready_s = '0;
  logic [1:0][19:0]  out_pix_s;
  logic [1:0]        busy_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int prod3(input logic [23:0] d, input logic [23:0] w);
    int s = 0;
    logic [23:0] td, tw;
    logic [7:0] pb;
    logic signed [7:0] wb;
    for (int i = 0; i < 3; i++) begin
      td = d << (8 * i);
      tw = w << (8 * i);
      pb = td[23:16];
      wb = tw[23:16];
      s += int'(pb) * int'(wb);
    end
    return s;
  endfunction

  function automatic logic [23:0] row(input logic [71:0] v, input int r);
    logic [71:0] t;
    t = v << (24 * r);
    return t[71:48];
  endfunction

  function automatic logic [19:0] window_sum(input logic [71:0] p, input logic [71:0] w);
    int s = 0;
    for (int r = 0; r < 3; r++) s += prod3(row(p, r), row(w, r));
`ifdef SAT_CLIP_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
`endif
    return 20'(s);
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;
    logic [19:0] acc, d1, d2;

    conv3x3_mac_sequencer #(.MAC_LAT(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we_s[gi]),
      .cfg_weight (cfg_weight_s[gi]),
      .win_valid  (win_valid_s[gi]),
      .win_ready  (win_ready_s[gi]),
      .win_data   (win_data_s[gi]),
      .mac_start  (mac_start_s[gi]),
      .mac_data   (mac_data_s[gi]),
      .mac_weight (mac_weight_s[gi]),
      .mac_result (mac_result_s[gi]),
      .out_valid  (out_valid_s[gi]),
      .out_ready  (out_ready_s[gi]),
      .out_pix    (out_pix_s[gi]),
      .busy       (busy_s[gi])
    );

    // Behavioural MAC: accumulator followed by L-1 extra delay stages.
    always @(posedge clk) begin
      if (mac_start_s[gi]) acc <= 20'(prod3(mac_data_s[gi], mac_weight_s[gi]));
      else acc <= acc + 20'(prod3(mac_data_s[gi], mac_weight_s[gi]));
      d1 <= acc;
      d2 <= d1;
    end
    assign mac_result_s[gi] = (L == 1) ? acc : d2;
  end

  // Window-level model: acceptance cycle plus captured window/weights define every output.
  bit          m_act[2];
  int          m_acc[2];
  logic [71:0] m_win[2];
  logic [71:0] m_wt[2];
  logic [71:0] m_shadow[2];
  logic [19:0] m_exp[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_shadow[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int L;
      int off;
      L = (k == 0) ? 1 : 3;
      off = cyc - m_acc[k];
      if (chk_en) begin
        if (!m_act[k]) begin
          chk("idle_win_ready", win_ready_s[k], 1);
          chk("idle_busy", busy_s[k], 0);
          chk("idle_out_valid", out_valid_s[k], 0);
          chk("idle_mac_start", mac_start_s[k], 0);
          chk("idle_mac_data", mac_data_s[k], 0);
          chk("idle_mac_weight", mac_weight_s[k], 0);
        end else begin
          chk("act_win_ready", win_ready_s[k], 0);
          chk("act_busy", busy_s[k], 1);
          chk("act_mac_start", mac_start_s[k], (off == 1) ? 1 : 0);
          chk("act_mac_data", mac_data_s[k], (off >= 1 && off <= 3) ? row(m_win[k], off - 1) : 24'd0);
          chk("act_mac_weight", mac_weight_s[k], (off >= 1 && off <= 3) ? row(m_wt[k], off - 1) : 24'd0);
          chk("act_out_valid", out_valid_s[k], (off >= 4 + L) ? 1 : 0);
          if (off >= 4 + L) chk("act_out_pix", out_pix_s[k], m_exp[k]);
        end
      end
      if (rst) begin
        m_act[k] = 1'b0;
        m_shadow[k] = '0;
      end else begin
        if (!m_act[k] && win_valid_s[k]) begin
          m_act[k] = 1'b1;
          m_acc[k] = cyc;
          m_win[k] = win_data_s[k];
          m_wt[k]  = m_shadow[k];
          m_exp[k] = window_sum(win_data_s[k], m_shadow[k]);
        end else if (m_act[k] && off >= 4 + L && out_ready_s[k]) begin
          m_act[k] = 1'b0;
        end
        if (cfg_we_s[k]) m_shadow[k] = cfg_weight_s[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int k, input logic [71:0] w);
    cfg_weight_s[k] = w;
    cfg_we_s[k] = 1'b1;
    tick();
    cfg_we_s[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [71:0] w, input bit keep, output int ac);
    ac = -1;
    win_data_s[k] = w;
    win_valid_s[k] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (win_ready_s[k]) begin
        ac = cyc;
        break;
      end
    end
    tick();
    if (!keep) win_valid_s[k] = 1'b0;
    if (ac < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: inst %0d window not accepted within 40 cycles", k);
    end
  endtask

  task automatic recv(input int k, output logic [19:0] pix, output int oc);
    oc = -1;
    pix = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid_s[k]) begin
        pix = out_pix_s[k];
        oc = cyc;
        break;
      end
    end
    tick();
    if (oc < 0) begin
      checks++;
      errors++;
      $display("FAIL recv_timeout: inst %0d no out_valid within 60 cycles", k);
    end
  endtask

  initial begin
    int a, a2, o, h;
    logic [19:0] p, p_hold;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_win_ready", win_ready_s[0], 1);
    chk("rst_busy", busy_s[0], 0);
    chk("rst_out_valid", out_valid_s[0], 0);
    chk("rst_mac_start", mac_start_s[0], 0);
    chk("rst_mac_data", mac_data_s[0], 0);
    chk("rst_mac_weight", mac_weight_s[0], 0);
    chk("rst_out_pix", out_pix_s[0], 0);
    tick();
    cfg(0, LAP);
    cfg(1, LAP);
    out_ready_s = 2'b11;

    // Laplacian on the reference window, MAC_LAT=1 latency
    send(0, W2, 0, a);
    recv(0, p, o);
    chk("t2_pix", p, EXP2);
    chk("t2_latency", o - a, 5);
    $display("win W2 -> out_pix %0h at T+%0d", p, o - a);

    // flat and centre-only windows
    send(0, W10, 0, a);
    recv(0, p, o);
    chk("t3_flat", p, 0);
    $display("win W10 -> out_pix %0h", p);
    send(0, WC, 0, a);
    recv(0, p, o);
    chk("t3_centre", p, EXP_C);
    $display("win WC -> out_pix %0h", p);

    // downstream stall with a pending window, then back-to-back acceptance
    out_ready_s[0] = 1'b0;
    send(0, WC, 0, a);
    recv(0, p_hold, o);
    win_data_s[0] = W10;
    win_valid_s[0] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid_s[0], 1);
      chk("t4_hold_pix", out_pix_s[0], EXP_C);
      chk("t4_hold_ready", win_ready_s[0], 0);
      tick();
    end
    h = cyc;
    out_ready_s[0] = 1'b1;
    send(0, W10, 0, a2);
    chk("t4_b2b_accept", a2, h + 1);
    recv(0, p, o);
    chk("t4_pending_pix", p, 0);
    $display("stall: held %0h, pending accepted at +%0d", p_hold, a2 - h);

    // weight update mid-window does not touch the window in flight
    send(0, W2, 0, a);
    tick();
    cfg_weight_s[0] = ONES;
    cfg_we_s[0] = 1'b1;
    tick();
    cfg_we_s[0] = 1'b0;
    recv(0, p, o);
    chk("t5_inflight", p, EXP2);
    send(0, ONES, 0, a);
    recv(0, p, o);
    chk("t5_new_weights", p, 9);
    $display("cfg mid-window: next window -> out_pix %0h", p);

    // weight write in the acceptance cycle applies from the following window
    cfg_weight_s[0] = LAP;
    cfg_we_s[0] = 1'b1;
    send(0, ONES, 0, a);
    cfg_we_s[0] = 1'b0;
    recv(0, p, o);
    chk("cfg_same_cycle_old", p, 9);
    send(0, ONES, 0, a);
    recv(0, p, o);
    chk("cfg_same_cycle_new", p, 0);
    $display("cfg at accept: old %0d then new %0h", 9, p);

    // reset mid-ROW1 aborts the window
    send(0, W2, 0, a);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_busy", busy_s[0], 0);
    chk("t1_win_ready", win_ready_s[0], 1);
    chk("t1_out_valid", out_valid_s[0], 0);
    chk("t1_mac_start", mac_start_s[0], 0);
    chk("t1_out_pix", out_pix_s[0], 0);
    tick();
    cfg(0, LAP);
    cfg(1, LAP);
    send(0, W2, 0, a);
    recv(0, p, o);
    chk("t1_after_reset", p, EXP2);
    $display("after mid-window reset -> out_pix %0h", p);

    // MAC_LAT=3 instance: latency and back-to-back spacing
    send(1, W2, 1, a);
    send(1, WC, 0, a2);
    chk("t6_spacing", a2 - a, 8);
    recv(1, p, o);
    chk("t6_latency", o - a2, 7);
    chk("t6_pix", p, EXP_C);
    $display("MAC_LAT=3: accepts %0d apart, out_valid at T+%0d, out_pix %0h", a2 - a, o - a2, p);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
